// File: rtl/sfp_pkg.sv
// sfp_pkg: shared sfp_row inst encodings and sequencer states
package sfp_pkg;
  localparam logic [1:0] INST_IDLE = 2'b00;
  localparam logic [1:0] INST_ACC  = 2'b10;
  localparam logic [1:0] INST_DIV  = 2'b01;
  typedef enum logic [2:0] {IDLE, ACC, DIV, WAIT, HOLD} state_t;
endpackage

// File: rtl/sfp_lane_sign.sv
// sfp_lane_sign: restores the sign of one lane by conditional two's-complement negate
module sfp_lane_sign #(
  parameter int W = 20
) (
  input  logic         neg,
  input  logic [W-1:0] mag,
  output logic [W-1:0] y
);
  always_comb y = neg ? ~mag + 1'b1 : mag;
endmodule

// File: rtl/sfp_seq.sv
// sfp_seq: sequences one psum row through sfp_row (ACC, DIV) and returns the sign-restored row
module sfp_seq import sfp_pkg::*; #(
  parameter int col     = 8,
  parameter int bw      = 8,
  parameter int bw_psum = 2*bw+4,
  parameter int DIV_LAT = 1,
  parameter int CNT_W   = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [col*bw_psum-1:0] in_data,
  output logic [1:0]             inst,
  output logic [col*bw_psum-1:0] sfp_in,
  input  logic [col*bw_psum-1:0] sfp_out,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [col*bw_psum-1:0] out_data,
  output logic                   out_zero,
  output logic                   busy,
  output logic [CNT_W-1:0]       row_cnt
);
  localparam int WC_W = (DIV_LAT > 1) ? $clog2(DIV_LAT) : 1;
  state_t                 state;
  logic [col-1:0]         sign_q;
  logic [col-1:0]         msb;
  logic [WC_W-1:0]        wcnt;
  logic [col*bw_psum-1:0] signed_out;
  logic                   accept;
  logic                   done;
  genvar k;
  generate
    for (k = 0; k < col; k++) begin : g_lane
      assign msb[k] = in_data[bw_psum*(k+1)-1];
      sfp_lane_sign #(.W(bw_psum)) u_sign (
        .neg (sign_q[k]),
        .mag (sfp_out[bw_psum*k +: bw_psum]),
        .y   (signed_out[bw_psum*k +: bw_psum])
      );
    end
  endgenerate
  always_comb begin
    out_valid = state == HOLD;
    busy      = state != IDLE;
    done      = out_valid && out_ready;
    in_ready  = (state == IDLE) || done;
    accept    = in_valid && in_ready;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      inst     <= INST_IDLE;
      sfp_in   <= '0;
      out_data <= '0;
      out_zero <= 1'b0;
      sign_q   <= '0;
      wcnt     <= '0;
      row_cnt  <= '0;
    end else begin
      inst <= INST_IDLE;
      if (done) row_cnt <= row_cnt + 1'b1;
      case (state)
        IDLE, HOLD: begin
          if (accept) begin
            sfp_in <= in_data;
            sign_q <= msb;
            if (in_data == '0) begin
              out_data <= '0;
              out_zero <= 1'b1;
              state    <= HOLD;
            end else begin
              inst  <= INST_ACC;
              state <= ACC;
            end
          end else if (done) begin
            state <= IDLE;
          end
        end
        ACC: begin
          inst  <= INST_DIV;
          state <= DIV;
        end
        DIV: begin
          wcnt  <= WC_W'(DIV_LAT - 1);
          state <= WAIT;
        end
        WAIT: begin
          if (wcnt == '0) begin
            out_data <= signed_out;
            out_zero <= 1'b0;
            state    <= HOLD;
          end else begin
            wcnt <= wcnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sfp_seq.sv
// tb_sfp_seq: directed scoreboard bench pairing sfp_seq with a behavioural sfp_row
module tb_sfp_seq;
  localparam int L = 20;
  localparam int C = 8;
  localparam int LW = L*C;
  logic clk = 0;
  logic reset = 0;
  logic in_valid = 0;
  logic in_ready;
  logic [LW-1:0] in_data = '0;
  logic [1:0] inst;
  logic [LW-1:0] sfp_in;
  logic [LW-1:0] sfp_out = '0;
  logic out_valid;
  logic out_ready = 1;
  logic [LW-1:0] out_data;
  logic out_zero;
  logic busy;
  logic [7:0] row_cnt;
  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] exp_cnt = 0;
  typedef struct {logic [LW-1:0] d; logic z;} exp_t;
  exp_t sb[$];
  logic [23:0] row_sum = 0;
  always #5 clk = ~clk;
  sfp_seq #(.col(C), .bw(8), .bw_psum(L), .DIV_LAT(1), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .inst(inst), .sfp_in(sfp_in), .sfp_out(sfp_out), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_zero(out_zero), .busy(busy),
    .row_cnt(row_cnt)
  );
  function automatic logic [L-1:0] mag(input logic [L-1:0] x);
    return x[L-1] ? ~x + 1'b1 : x;
  endfunction
  function automatic logic [23:0] sum_row(input logic [LW-1:0] d);
    logic [23:0] s = 0;
    for (int k = 0; k < C; k++) s += 24'(mag(d[k*L +: L]));
    return s;
  endfunction
  function automatic logic [L-1:0] div_lane(input logic [L-1:0] x, input logic [23:0] s);
    logic [63:0] num;
    num = {44'd0, mag(x)} << 20;
    return (s == 0) ? '0 : L'(num / {40'd0, s});
  endfunction
  // sfp_row stand-in: sums magnitudes on ACC, emits (|x|<<20)/sum on DIV
  always @(posedge clk) begin
    if (inst == 2'b10) row_sum <= sum_row(sfp_in);
    if (inst == 2'b01)
      for (int k = 0; k < C; k++) sfp_out[k*L +: L] <= div_lane(sfp_in[k*L +: L], row_sum);
  end
  function automatic logic [LW-1:0] expect_row(input logic [LW-1:0] d);
    logic [LW-1:0] r;
    logic [L-1:0] q;
    logic [23:0] s;
    s = sum_row(d);
    for (int k = 0; k < C; k++) begin
      q = div_lane(d[k*L +: L], s);
      r[k*L +: L] = d[k*L+L-1] ? ~q + 1'b1 : q;
    end
    return r;
  endfunction
  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      chk("sb_nonempty", LW'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("out_data", out_data, e.d);
        chk("out_zero", LW'(out_zero), LW'(e.z));
      end
      exp_cnt++;
    end
  end
  task automatic send(input logic [LW-1:0] d, input logic [LW-1:0] e, input logic z,
                      output time t);
    int i;
    in_valid = 1;
    in_data = d;
    sb.push_back('{d: e, z: z});
    for (i = 0; i < 60 && !in_ready; i++) @(negedge clk);
    chk("accept_timeout", LW'(in_ready), 1);
    @(posedge clk);
    t = $time;
    #1 in_valid = 0;
  endtask
  task automatic drain();
    for (int i = 0; i < 60 && (sb.size() != 0 || out_valid); i++) begin
      @(negedge clk);
      #1;
    end
    chk("drain_timeout", LW'(sb.size() == 0 && !out_valid), 1);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [LW-1:0] ones, ones_e, r, held;
    logic [7:0] c0;
    time t, tp;
    ones = {C{20'd1}};
    ones_e = {C{20'h20000}};
    #12;
    chk("rst_inst", LW'(inst), 0);
    chk("rst_busy", LW'(busy), 0);
    chk("rst_out_valid", LW'(out_valid), 0);
    chk("rst_out_zero", LW'(out_zero), 0);
    chk("rst_row_cnt", LW'(row_cnt), 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_sfp_in", sfp_in, 0);
    @(negedge clk) reset = 1;
    // 1: all +1
    send(ones, ones_e, 0, t);
    @(negedge clk);
    chk("t1_inst_acc", LW'(inst), 2'b10);
    chk("t1_busy", LW'(busy), 1);
    @(negedge clk);
    chk("t1_inst_div", LW'(inst), 2'b01);
    @(negedge clk);
    chk("t1_inst_idle", LW'(inst), 0);
    chk("t1_not_valid_yet", LW'(out_valid), 0);
    @(negedge clk);
    chk("t1_valid_at_3", LW'(out_valid), 1);
    drain();
    chk("t1_row_cnt", LW'(row_cnt), 1);
    // 2: mixed sign
    send({{7{20'd4}}, 20'hFFFFC}, {{7{20'h20000}}, 20'hE0000}, 0, t);
    drain();
    // 3: all-zero bypass
    send('0, '0, 1, t);
    @(negedge clk);
    chk("t3_valid_at_1", LW'(out_valid), 1);
    chk("t3_out_zero", LW'(out_zero), 1);
    chk("t3_inst", LW'(inst), 0);
    drain();
    // 4: backpressure in HOLD
    out_ready = 0;
    send({C{20'd2}}, ones_e, 0, t);
    for (int i = 0; i < 10 && !out_valid; i++) @(negedge clk);
    chk("t4_valid", LW'(out_valid), 1);
    held = out_data;
    c0 = row_cnt;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_hold_valid", LW'(out_valid), 1);
      chk("t4_hold_data", out_data, held);
      chk("t4_in_ready", LW'(in_ready), 0);
      chk("t4_inst", LW'(inst), 0);
    end
    @(posedge clk);
    #1 out_ready = 1;
    drain();
    chk("t4_row_cnt_inc", LW'(row_cnt), LW'(c0 + 8'd1));
    chk("t4_row_cnt", LW'(row_cnt), LW'(exp_cnt));
    // 5: async reset while in DIV
    send(ones, ones_e, 0, t);
    @(posedge clk);
    #2 reset = 0;
    #1;
    chk("t5_inst", LW'(inst), 0);
    chk("t5_busy", LW'(busy), 0);
    chk("t5_out_valid", LW'(out_valid), 0);
    chk("t5_sfp_in", sfp_in, 0);
    chk("t5_out_data", out_data, 0);
    chk("t5_row_cnt", LW'(row_cnt), 0);
    sb.delete();
    exp_cnt = 0;
    @(negedge clk) reset = 1;
    send(ones, ones_e, 0, t);
    drain();
    chk("t5_row_cnt_after", LW'(row_cnt), 1);
    // 6: sustained throughput
    c0 = row_cnt;
    tp = 0;
    for (int n = 0; n < 10; n++) begin
      for (int k = 0; k < C; k++) r[k*L +: L] = L'($urandom_range(0, 2000)) - 20'd1000;
      if (n == 3) r[L-1:0] = 20'h80000;
      else r[L-1:0] = 20'd1 + 20'($urandom_range(0, 50));
      send(r, expect_row(r), 0, t);
      if (n > 0) chk("t6_interval", LW'(t - tp), 40);
      tp = t;
    end
    drain();
    chk("t6_row_cnt_plus10", LW'(row_cnt), LW'(c0 + 8'd10));
    chk("t6_row_cnt", LW'(row_cnt), LW'(exp_cnt));
    for (int i = 0; i < 300 && exp_cnt != 8'd255; i++) begin
      send('0, '0, 1, t);
      drain();
    end
    chk("t6_row_cnt_255", LW'(row_cnt), 255);
    send(ones, ones_e, 0, t);
    drain();
    chk("t6_row_cnt_wrap", LW'(row_cnt), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
